// File: rtl/mac_array_pkg.sv
// mac_array shared definitions: default geometry/widths and FSM states.
package mac_array_pkg;

  localparam int MAC_ROW_D        = 16;
  localparam int MAC_COL_D        = 16;
  localparam int IFMAP_BITWIDTH_D = 16;
  localparam int W_BITWIDTH_D     = 8;
  localparam int OFMAP_BITWIDTH_D = 32;

  typedef enum logic [1:0] {
    IDLE,
    W_LOAD,
    W_READY,
    RUN
  } state_t;

endpackage

// File: rtl/mac_pe.sv
// Weight-stationary PE: shift-through weight, act/valid pass, psum MAC.
// MAC_ARRAY_SAT_EN selects saturating accumulation instead of wrap.
module mac_pe
  import mac_array_pkg::*;
#(
  parameter int IW = IFMAP_BITWIDTH_D,
  parameter int WW = W_BITWIDTH_D,
  parameter int OW = OFMAP_BITWIDTH_D
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          w_shift,
  input  logic [WW-1:0] w_in,
  output logic [WW-1:0] w_out,
  input  logic [IW-1:0] act_in,
  input  logic          vld_in,
  output logic [IW-1:0] act_out,
  output logic          vld_out,
  input  logic [OW-1:0] psum_in,
  output logic [OW-1:0] psum_out,
  output logic [OW-1:0] psum_reg
);

  localparam int PW = IW + WW;

  logic [WW-1:0] w_q;
  logic [IW-1:0] act_q;
  logic          vld_q;
  logic [OW-1:0] psum_q;
  logic [OW-1:0] psum_nx;

  logic signed [PW-1:0] a_x;
  logic signed [PW-1:0] w_x;
  logic signed [PW-1:0] prod;
  logic        [OW:0]   sum;

  assign a_x  = {{WW{act_in[IW-1]}}, act_in};
  assign w_x  = {{IW{w_q[WW-1]}}, w_q};
  assign prod = a_x * w_x;
  assign sum  = {psum_in[OW-1], psum_in}
              + {{(OW + 1 - PW){prod[PW-1]}}, prod};

`ifdef MAC_ARRAY_SAT_EN
  always_comb begin
    psum_nx = sum[OW-1:0];
    if (sum[OW] != sum[OW-1])
      psum_nx = sum[OW] ? {1'b1, {(OW-1){1'b0}}}
                        : {1'b0, {(OW-1){1'b1}}};
  end
`else
  logic unused_msb;
  assign unused_msb = sum[OW];
  assign psum_nx    = sum[OW-1:0];
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_q    <= '0;
      act_q  <= '0;
      vld_q  <= 1'b0;
      psum_q <= '0;
    end else begin
      if (w_shift) w_q <= w_in;
      act_q <= act_in;
      vld_q <= vld_in;
      // hold on bubbles so the bottom row keeps its last result
      if (vld_in) psum_q <= psum_nx;
    end
  end

  assign w_out    = w_q;
  assign act_out  = act_q;
  assign vld_out  = vld_q;
  assign psum_out = vld_q ? psum_q : '0;
  assign psum_reg = psum_q;

endmodule

// File: rtl/mac_array.sv
// Weight-stationary systolic MAC array: load FSM plus a grid of mac_pe.
// MAC_ARRAY_SAT_EN enables saturating accumulation in every PE.
module mac_array
  import mac_array_pkg::*;
#(
  parameter int MAC_ROW        = MAC_ROW_D,
  parameter int MAC_COL        = MAC_COL_D,
  parameter int IFMAP_BITWIDTH = IFMAP_BITWIDTH_D,
  parameter int W_BITWIDTH     = W_BITWIDTH_D,
  parameter int OFMAP_BITWIDTH = OFMAP_BITWIDTH_D
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       w_prefetch_in,
  input  logic                       w_enable_in,
  input  logic [MAC_COL-1:0][W_BITWIDTH-1:0]     w_data_in,
  input  logic                       ifmap_start_in,
  input  logic [MAC_ROW-1:0]         ifmap_enable_in,
  input  logic [MAC_ROW-1:0][IFMAP_BITWIDTH-1:0] ifmap_data_in,
  output logic [MAC_COL-1:0]         ofmap_valid_out,
  output logic [MAC_COL-1:0][OFMAP_BITWIDTH-1:0] ofmap_data_out
);

  localparam int CW = $clog2(MAC_ROW + 1);

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] shift_cnt;
  logic          start_pend;
  logic          w_shift;
  logic          last_shift;
  logic          run;
  logic          pipe_vld;

  logic [W_BITWIDTH-1:0]     w_q    [MAC_ROW][MAC_COL];
  logic [IFMAP_BITWIDTH-1:0] act_q  [MAC_ROW][MAC_COL];
  logic [OFMAP_BITWIDTH-1:0] psum_o [MAC_ROW][MAC_COL];
  logic [OFMAP_BITWIDTH-1:0] psum_r [MAC_ROW][MAC_COL];
  logic [MAC_ROW*MAC_COL-1:0] vld;

  assign w_shift    = (state == W_LOAD) && w_enable_in;
  assign last_shift = w_shift && (shift_cnt == CW'(MAC_ROW - 1));
  assign run        = (state == RUN);
  assign pipe_vld   = |vld;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (w_prefetch_in) state_nx = W_LOAD;
      W_LOAD:
        if (last_shift) state_nx = W_READY;
      W_READY:
        if (w_prefetch_in) state_nx = W_LOAD;
        else if (ifmap_start_in || start_pend) state_nx = RUN;
      RUN:
        if (!(|ifmap_enable_in) && !pipe_vld) state_nx = W_READY;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      shift_cnt  <= '0;
      start_pend <= 1'b0;
    end else begin
      state <= state_nx;
      if (state != W_LOAD) shift_cnt <= '0;
      else if (w_shift) shift_cnt <= shift_cnt + 1'b1;
      // a start seen during the load is replayed once W_READY is reached
      start_pend <= (state == W_LOAD) && (start_pend || ifmap_start_in);
    end
  end

  for (genvar r = 0; r < MAC_ROW; r++) begin : g_row
    for (genvar c = 0; c < MAC_COL; c++) begin : g_col
      logic [W_BITWIDTH-1:0]     w_in;
      logic [IFMAP_BITWIDTH-1:0] a_in;
      logic                      v_in;
      logic [OFMAP_BITWIDTH-1:0] p_in;

      if (r == 0) begin : g_top
        assign w_in = w_data_in[c];
        assign p_in = '0;
      end else begin : g_mid
        assign w_in = w_q[r-1][c];
        assign p_in = psum_o[r-1][c];
      end

      if (c == 0) begin : g_left
        assign a_in = ifmap_data_in[r];
        assign v_in = run && ifmap_enable_in[r];
      end else begin : g_inner
        assign a_in = act_q[r][c-1];
        assign v_in = vld[r*MAC_COL + c - 1];
      end

      mac_pe #(
        .IW (IFMAP_BITWIDTH),
        .WW (W_BITWIDTH),
        .OW (OFMAP_BITWIDTH)
      ) u_pe (
        .clk      (clk),
        .rstn     (rstn),
        .w_shift  (w_shift),
        .w_in     (w_in),
        .w_out    (w_q[r][c]),
        .act_in   (a_in),
        .vld_in   (v_in),
        .act_out  (act_q[r][c]),
        .vld_out  (vld[r*MAC_COL + c]),
        .psum_in  (p_in),
        .psum_out (psum_o[r][c]),
        .psum_reg (psum_r[r][c])
      );

      if (r == MAC_ROW - 1) begin : g_bot
        logic unused_bot;
        assign unused_bot = ^{w_q[r][c], psum_o[r][c]};
        assign ofmap_valid_out[c] = vld[r*MAC_COL + c];
        assign ofmap_data_out[c]  = psum_r[r][c];
      end else begin : g_nbot
        logic unused_raw;
        assign unused_raw = ^psum_r[r][c];
      end

      if (c == MAC_COL - 1) begin : g_right
        logic unused_act;
        assign unused_act = ^act_q[r][c];
      end
    end
  end

endmodule

// File: tb/tb_mac_array.sv
// Self-checking bench for mac_array: directed and random streams
// checked cycle by cycle against a dot-product reference model.
module tb_mac_array;

  localparam int R  = 16;
  localparam int C  = 16;
  localparam int IB = 16;
  localparam int WB = 8;
  localparam int OB = 32;
  localparam int NS = 32;

  logic clk = 1'b0;
  logic rstn;
  logic w_prefetch;
  logic w_enable;
  logic [C-1:0][WB-1:0] w_data;
  logic start;
  logic [R-1:0] en_in;
  logic [R-1:0][IB-1:0] x_in;
  logic [C-1:0] vout;
  logic [C-1:0][OB-1:0] dout;

  int tests = 0;
  int fails = 0;

  int wt [C][R];
  int xs [R][NS];
  bit ens [NS];
  int exp_d [C][NS];
  int last_d [C];

  always #5 clk = ~clk;

  mac_array dut (
    .clk             (clk),
    .rstn            (rstn),
    .w_prefetch_in   (w_prefetch),
    .w_enable_in     (w_enable),
    .w_data_in       (w_data),
    .ifmap_start_in  (start),
    .ifmap_enable_in (en_in),
    .ifmap_data_in   (x_in),
    .ofmap_valid_out (vout),
    .ofmap_data_out  (dout)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int dot(int c, int k);
    longint acc = 0;
    for (int r = 0; r < R; r++) begin
      acc += longint'(xs[r][k]) * longint'(wt[c][r]);
`ifdef MAC_ARRAY_SAT_EN
      if (acc > 64'sd2147483647) acc = 64'sd2147483647;
      if (acc < -64'sd2147483648) acc = -64'sd2147483648;
`else
      acc = longint'(int'(acc));
`endif
    end
    return int'(acc);
  endfunction

  task automatic idle_inputs();
    w_prefetch = 1'b0;
    w_enable   = 1'b0;
    w_data     = '0;
    start      = 1'b0;
    en_in      = '0;
    x_in       = '0;
  endtask

  // Row R-1 goes in first, row 0 last; then junk that must be ignored.
  task automatic load_weights();
    @(negedge clk);
    w_prefetch = 1'b1;
    for (int j = 0; j < R; j++) begin
      @(negedge clk);
      w_prefetch = 1'b0;
      w_enable   = 1'b1;
      for (int c = 0; c < C; c++) w_data[c] = WB'(wt[c][R-1-j]);
    end
    @(negedge clk);
    w_data = {C{8'($urandom)}};
    en_in  = R'($urandom);
    x_in   = {R{16'($urandom)}};
    @(negedge clk);
    idle_inputs();
  endtask

  // Start pulse at step 0; sample k enters row r at step 1+k+r and
  // must appear on column c at step 1+k+R+c.
  task automatic stream(int n, int abort_at, bit live);
    int  steps;
    bit  ev;
    int  k;
    steps = n + R + C + 3;
    for (int c = 0; c < C; c++)
      for (int kk = 0; kk < n; kk++) exp_d[c][kk] = dot(c, kk);
    for (int s = 0; s < steps; s++) begin
      @(negedge clk);
      for (int c = 0; c < C; c++) begin
        k  = s - 1 - R - c;
        ev = live && k >= 0 && k < n && ens[k];
        if (ev) last_d[c] = exp_d[c][k];
        chk($sformatf("valid s%0d c%0d", s, c), 32'(vout[c]), 32'(ev));
        chk($sformatf("data s%0d c%0d", s, c), dout[c], last_d[c]);
      end
      start = (s == 0);
      for (int r = 0; r < R; r++) begin
        k = s - 1 - r;
        en_in[r] = k >= 0 && k < n && ens[k];
        x_in[r]  = en_in[r] ? IB'(xs[r][k]) : IB'($urandom);
      end
      if (s == abort_at) begin
        rstn = 1'b0;
        for (int c = 0; c < C; c++) last_d[c] = 0;
        break;
      end
    end
    idle_inputs();
  endtask

  task automatic all_ens(int n);
    for (int k = 0; k < NS; k++) ens[k] = (k < n);
  endtask

  task automatic rand_w();
    for (int c = 0; c < C; c++)
      for (int r = 0; r < R; r++) wt[c][r] = int'($urandom_range(255)) - 128;
  endtask

  task automatic rand_x(int n);
    for (int r = 0; r < R; r++)
      for (int k = 0; k < n; k++) xs[r][k] = int'($urandom_range(65535)) - 32768;
  endtask

  initial begin
    idle_inputs();
    rstn = 1'b0;
    for (int c = 0; c < C; c++) last_d[c] = 0;
    repeat (3) @(negedge clk);
    chk("reset valid", 32'(vout), 32'd0);
    chk("reset data_or", 32'(|dout), 32'd0);
    rstn = 1'b1;

    // identity weights: column c echoes row c
    for (int c = 0; c < C; c++)
      for (int r = 0; r < R; r++) wt[c][r] = (r == c) ? 1 : 0;
    for (int r = 0; r < R; r++)
      for (int k = 0; k < 8; k++) xs[r][k] = k + r;
    all_ens(8);
    load_weights();
    stream(8, -1, 1'b1);
    chk("identity c5 last", dout[5], 32'd12);

    // signed corner
    for (int c = 0; c < C; c++)
      for (int r = 0; r < R; r++) wt[c][r] = -128;
    for (int r = 0; r < R; r++)
      for (int k = 0; k < 4; k++) xs[r][k] = -32768;
    all_ens(4);
    load_weights();
    stream(4, -1, 1'b1);
    chk("corner c15", dout[15], 32'd67108864);

    // shift order: row r holds r+1
    for (int c = 0; c < C; c++)
      for (int r = 0; r < R; r++) wt[c][r] = r + 1;
    for (int r = 0; r < R; r++)
      for (int k = 0; k < 5; k++) xs[r][k] = 1;
    all_ens(5);
    load_weights();
    stream(5, -1, 1'b1);
    chk("order c0", dout[0], 32'd136);

    // gap at sample 3, random data
    rand_w();
    rand_x(10);
    all_ens(10);
    ens[3] = 1'b0;
    load_weights();
    stream(10, -1, 1'b1);

    // random stream with random bubbles
    rand_w();
    rand_x(24);
    for (int k = 0; k < NS; k++)
      ens[k] = (k < 24) && ((k % 4 == 0) || ($urandom_range(3) != 0));
    load_weights();
    stream(24, -1, 1'b1);

    // reset five cycles into RUN
    rand_x(12);
    all_ens(12);
    load_weights();
    stream(12, 6, 1'b1);
    @(negedge clk);
    chk("abort valid", 32'(vout), 32'd0);
    chk("abort data_or", 32'(|dout), 32'd0);
    rstn = 1'b1;

    // back in IDLE: stream without reload must stay silent
    stream(6, -1, 1'b0);

    rand_w();
    rand_x(12);
    all_ens(12);
    load_weights();
    stream(12, -1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
